// File: rtl/radio_serial_rx.sv
// radio_serial_rx: 16x-oversampled async serial receiver with majority vote and valid/ready output.
// Define RADIO_RX_PARITY_EN to add an even parity bit after the data bits.
module radio_serial_rx #(
  parameter int BAUD_DIV = 27,
  parameter int DATA_W   = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              serial_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun
);
  localparam int TW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_W);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RADIO_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q;
  logic [TW-1:0] tc_q, tc_d;
  logic [3:0] sc_q, sc_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [1:0] v_q, v_d;
  logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
  logic armed_q, armed_d, valid_q, valid_d, fe_q, fe_d, ov_q, ov_d;
  logic tick, mid, wrap, maj, last, done, bad, ld;
  assign tick = state_q != IDLE && tc_q == TW'(BAUD_DIV - 1);
  assign mid  = tick && sc_q == 4'd9;
  assign wrap = tick && sc_q == 4'd15;
  assign maj  = (v_q[0] & v_q[1]) | (s2_q & (v_q[0] | v_q[1]));
  assign last = bc_q == BW'(DATA_W - 1);
  assign done = state_q == STOP && mid;
`ifdef RADIO_RX_PARITY_EN
  logic par_q, par_d, pe_q, pe_d;
  assign bad = par_q != ^sh_q;
  assign rx_parity_err = pe_q;
`else
  assign bad = 1'b0;
  assign rx_parity_err = 1'b0;
`endif
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (armed_q && !s2_q) state_d = START;
      START:   if (mid && maj) state_d = IDLE;
               else if (wrap) state_d = DATA;
`ifdef RADIO_RX_PARITY_EN
      DATA:    if (wrap && last) state_d = PARITY;
      PARITY:  if (wrap) state_d = STOP;
`else
      DATA:    if (wrap && last) state_d = STOP;
`endif
      STOP:    if (mid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Stop-bit verdict is taken at its midpoint so the next start edge can be caught half a bit early.
  always_comb begin
    tc_d    = (state_q == IDLE || tick) ? '0 : tc_q + 1'b1;
    sc_d    = state_q == IDLE ? 4'd0 : sc_q + {3'b0, tick};
    v_d     = {tick && sc_q == 4'd8 ? s2_q : v_q[1], tick && sc_q == 4'd7 ? s2_q : v_q[0]};
    bc_d    = state_q != DATA ? '0 : bc_q + {{(BW-1){1'b0}}, wrap};
    sh_d    = (state_q == DATA && mid) ? {maj, sh_q[DATA_W-1:1]} : sh_q;
    ld      = done && maj && !bad && (!valid_q || rx_ready);
    fe_d    = done && !maj;
    ov_d    = done && maj && !bad && valid_q && !rx_ready;
    valid_d = ld || (valid_q && !rx_ready);
    data_d  = ld ? sh_q : data_q;
    armed_d = fe_d ? 1'b0 : (state_q == IDLE && s2_q) ? 1'b1 : armed_q;
`ifdef RADIO_RX_PARITY_EN
    par_d   = (state_q == PARITY && mid) ? maj : par_q;
    pe_d    = done && maj && bad;
`endif
  end
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      tc_q    <= '0;
      sc_q    <= '0;
      bc_q    <= '0;
      v_q     <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef RADIO_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      s1_q    <= serial_data;
      s2_q    <= s1_q;
      tc_q    <= tc_d;
      sc_q    <= sc_d;
      bc_q    <= bc_d;
      v_q     <= v_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef RADIO_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end
  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = fe_q;
  assign rx_overrun   = ov_q;
endmodule
